netlist_inst_decoder: RTL and testbench



---
 rtl/netlist_inst_decoder_pkg.sv | 54 +++++
 rtl/netlist_inst_decoder_if.sv | 29 ++
 rtl/net_name_hasher.sv | 27 ++
 rtl/netlist_inst_decoder.sv | 199 +++++++++++++++++++
 tb/tb_netlist_inst_decoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/netlist_inst_decoder_pkg.sv
// Shared types and constants for the netlist instance-line decoder.
// Keywords are packed right-aligned as the last four ASCII bytes seen.
package netlist_dec_pkg;

    typedef enum logic [2:0] {
        T_OTHER = 3'd0,
        T_R     = 3'd1,
        T_C     = 3'd2,
        T_GND   = 3'd3,
        T_PORT  = 3'd4
    } comp_type_e;

    typedef enum logic [2:0] {
        LSTART, KEYWORD, PARAMS, NAME, NETS, TAIL, SKIP, EMIT
    } state_e;

    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;

    localparam logic [31:0] KW_R    = 32'h0000_0052;
    localparam logic [31:0] KW_C    = 32'h0000_0043;
    localparam logic [31:0] KW_GND  = 32'h0047_4E44;
    localparam logic [31:0] KW_PORT = 32'h506F_7274;
    localparam logic [31:0] KW_DULE = 32'h6475_6C65;

    localparam int HASH_MULT = 31;

    function automatic logic is_blank(input logic [7:0] c);
        return (c == CH_SPACE) || (c == CH_TAB);
    endfunction

    function automatic logic is_ident(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A) ||
               (c >= 8'h30 && c <= 8'h39) || (c == 8'h5F);
    endfunction

    function automatic comp_type_e kw_type(input logic [31:0] kw, input logic [3:0] len);
        comp_type_e t;
        t = T_OTHER;
        if (len == 4'd1 && kw == KW_R)         t = T_R;
        else if (len == 4'd1 && kw == KW_C)    t = T_C;
        else if (len == 4'd3 && kw == KW_GND)  t = T_GND;
        else if (len == 4'd4 && kw == KW_PORT) t = T_PORT;
        return t;
    endfunction

endpackage

// File: rtl/netlist_inst_decoder_if.sv
// Byte-in / record-out handshake bundle of the netlist instance decoder.
// slave is the decoder side, master is the byte source plus record consumer.
interface netlist_inst_decoder_if #(parameter int HASH_W = 16);
    import netlist_dec_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    comp_type_e        out_type;
    logic [3:0]        out_params;
    logic [3:0]        out_nets;
    logic              out_shorted;
    logic [HASH_W-1:0] out_name_hash;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_type, out_params, out_nets,
               out_shorted, out_name_hash, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_type, out_params, out_nets,
               out_shorted, out_name_hash, out_ovf
    );
endinterface

// File: rtl/net_name_hasher.sv
// Rolling h = h*31 + c hash of one name; clear wins over accumulate, otherwise holds.
// Single-cycle update, no flow control of its own.
module net_name_hasher
    import netlist_dec_pkg::*;
#(
    parameter int HASH_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_acc,
    input  logic [7:0]        i_chr,
    output logic [HASH_W-1:0] o_hash
);
    logic [HASH_W-1:0] r_hash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hash <= '0;
        else if (i_clr)
            r_hash <= '0;
        else if (i_acc)
            r_hash <= r_hash * HASH_W'(HASH_MULT) + HASH_W'(i_chr);
    end

    assign o_hash = r_hash;
endmodule

// File: rtl/netlist_inst_decoder.sv
// Decodes `Type #(params) Name(net, ...);` lines, one byte per cycle, into records; NETLIST_DEC_STATS_EN adds counters.
// Record valid the cycle after the ';' handshake; in_ready is low only while a record waits for out_ready.
module netlist_inst_decoder
    import netlist_dec_pkg::*;
#(
    parameter int HASH_W   = 16,
    parameter int MAX_NETS = 15
) (
    input  logic clk,
    input  logic rst_n,
    netlist_inst_decoder_if.slave bus
`ifdef NETLIST_DEC_STATS_EN
    ,
    output logic [15:0] stat_records,
    output logic [15:0] stat_shorted
`endif
);
    localparam logic [3:0] NETS_MAX = 4'(MAX_NETS);

    state_e            r_state, w_nxt;
    logic              r_rdy_en;
    logic [31:0]       r_kw;
    logic [3:0]        r_kw_len, r_depth, r_commas, r_params, r_nets;
    comp_type_e        r_type;
    logic              r_nonempty, r_ovf, r_short_ok, r_net_has, r_first_done;
    logic [HASH_W-1:0] r_name_hash;

    logic [7:0]        w_c;
    logic              w_fire, w_blank, w_nl, w_kw_mod;
    logic              w_cur_clr, w_cur_acc, w_fst_clr, w_fst_acc;
    logic [HASH_W-1:0] w_cur_hash, w_fst_hash;

    assign w_c      = bus.in_data;
    assign w_fire   = bus.in_valid && bus.in_ready;
    assign w_blank  = is_blank(w_c);
    assign w_nl     = (w_c == CH_NL);
    assign w_kw_mod = (r_kw == KW_DULE) && (r_kw_len == 4'd6 || r_kw_len == 4'd9);

    net_name_hasher #(.HASH_W(HASH_W)) u_cur_hash (
        .clk(clk), .rst_n(rst_n), .i_clr(w_cur_clr), .i_acc(w_cur_acc),
        .i_chr(w_c), .o_hash(w_cur_hash)
    );

    net_name_hasher #(.HASH_W(HASH_W)) u_first_hash (
        .clk(clk), .rst_n(rst_n), .i_clr(w_fst_clr), .i_acc(w_fst_acc),
        .i_chr(w_c), .o_hash(w_fst_hash)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LSTART;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_cur_clr = 1'b0;
        w_cur_acc = 1'b0;
        w_fst_clr = 1'b0;
        w_fst_acc = 1'b0;
        if (r_state == EMIT) begin
            if (bus.out_ready) w_nxt = LSTART;
        end else if (w_fire) begin
            if (w_nl) begin
                w_nxt = LSTART;
            end else begin
                case (r_state)
                    LSTART: begin
                        if (w_c == CH_SLASH) w_nxt = SKIP;
                        else if (is_ident(w_c)) begin
                            w_nxt     = KEYWORD;
                            w_cur_clr = 1'b1;
                        end else if (!w_blank) w_nxt = SKIP;
                    end
                    KEYWORD: if (w_blank || w_c == CH_HASH) w_nxt = w_kw_mod ? SKIP : PARAMS;
                    // With no parameter block the first other byte already belongs to the name.
                    PARAMS: begin
                        if (r_depth == 4'd0) begin
                            if (!w_blank && w_c != CH_HASH && w_c != CH_LPAR) begin
                                w_nxt     = NAME;
                                w_cur_acc = 1'b1;
                            end
                        end else if (w_c == CH_RPAR && r_depth == 4'd1) w_nxt = NAME;
                    end
                    NAME: begin
                        if (w_c == CH_LPAR) begin
                            w_nxt     = NETS;
                            w_cur_clr = 1'b1;
                            w_fst_clr = 1'b1;
                        end else if (!w_blank) w_cur_acc = 1'b1;
                    end
                    NETS: begin
                        if (w_c == CH_COMMA || w_c == CH_RPAR) begin
                            w_cur_clr = 1'b1;
                            if (w_c == CH_RPAR) w_nxt = TAIL;
                        end else if (!w_blank) begin
                            w_cur_acc = 1'b1;
                            w_fst_acc = !r_first_done;
                        end
                    end
                    TAIL: begin
                        if (w_c == CH_SEMI) w_nxt = EMIT;
                        else if (!w_blank) w_nxt = SKIP;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kw <= '0;        r_kw_len <= '0;      r_type <= T_OTHER;
            r_depth <= '0;     r_commas <= '0;      r_params <= '0;
            r_nets <= '0;      r_nonempty <= 1'b0;  r_ovf <= 1'b0;
            r_short_ok <= 1'b0; r_net_has <= 1'b0;  r_first_done <= 1'b0;
            r_name_hash <= '0;
        end else if (w_fire && !w_nl) begin
            case (r_state)
                LSTART: if (is_ident(w_c)) begin
                    r_kw <= {24'd0, w_c};  r_kw_len <= 4'd1;     r_type <= T_OTHER;
                    r_depth <= '0;         r_commas <= '0;       r_params <= '0;
                    r_nets <= '0;          r_nonempty <= 1'b0;   r_ovf <= 1'b0;
                    r_short_ok <= 1'b1;    r_net_has <= 1'b0;    r_first_done <= 1'b0;
                    r_name_hash <= '0;
                end
                KEYWORD: begin
                    if (w_blank || w_c == CH_HASH) r_type <= kw_type(r_kw, r_kw_len);
                    else begin
                        r_kw <= {r_kw[23:0], w_c};
                        if (r_kw_len != 4'hF) r_kw_len <= r_kw_len + 4'd1;
                    end
                end
                // The ')' that closes the block does not count as content: `#()` is zero params.
                PARAMS: begin
                    if (r_depth != 4'd0 && !w_blank && !(w_c == CH_RPAR && r_depth == 4'd1))
                        r_nonempty <= 1'b1;
                    if (w_c == CH_LPAR) begin
                        if (r_depth != 4'hF) r_depth <= r_depth + 4'd1;
                    end else if (w_c == CH_RPAR && r_depth != 4'd0) begin
                        r_depth <= r_depth - 4'd1;
                        if (r_depth == 4'd1 && r_nonempty) begin
                            if (r_commas == 4'hF) begin
                                r_params <= 4'hF;
                                r_ovf    <= 1'b1;
                            end else r_params <= r_commas + 4'd1;
                        end
                    end else if (w_c == CH_COMMA && r_depth == 4'd1) begin
                        if (r_commas == 4'hF) r_ovf <= 1'b1;
                        else r_commas <= r_commas + 4'd1;
                    end
                end
                NAME: if (w_c == CH_LPAR) r_name_hash <= w_cur_hash;
                NETS: begin
                    if (w_c == CH_COMMA || w_c == CH_RPAR) begin
                        r_net_has <= 1'b0;
                        if (w_c == CH_COMMA || r_net_has || r_nets != 4'd0) begin
                            if (r_nets == NETS_MAX) r_ovf <= 1'b1;
                            else r_nets <= r_nets + 4'd1;
                            if (w_cur_hash != w_fst_hash) r_short_ok <= 1'b0;
                            r_first_done <= 1'b1;
                        end
                    end else if (!w_blank) r_net_has <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = r_rdy_en && (r_state != EMIT);
    assign bus.out_valid     = (r_state == EMIT);
    assign bus.out_type      = r_type;
    assign bus.out_params    = r_params;
    assign bus.out_nets      = r_nets;
    assign bus.out_shorted   = r_short_ok && (r_nets >= 4'd2);
    assign bus.out_name_hash = r_name_hash;
    assign bus.out_ovf       = r_ovf;

`ifdef NETLIST_DEC_STATS_EN
    logic [15:0] r_stat_rec, r_stat_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rec <= '0;
            r_stat_sh  <= '0;
        end else if (r_state == EMIT && bus.out_ready) begin
            r_stat_rec <= r_stat_rec + 16'd1;
            if (r_short_ok && (r_nets >= 4'd2)) r_stat_sh <= r_stat_sh + 16'd1;
        end
    end

    assign stat_records = r_stat_rec;
    assign stat_shorted = r_stat_sh;
`endif
endmodule

// File: tb/tb_netlist_inst_decoder.sv
// Table-driven line vectors with a record scoreboard, plus stall and reset sequences.
module tb_netlist_inst_decoder;
    import netlist_dec_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    netlist_inst_decoder_if #(.HASH_W(16)) bus();
`ifdef NETLIST_DEC_STATS_EN
    logic [15:0] stat_records, stat_shorted;
`endif

    netlist_inst_decoder #(.HASH_W(16), .MAX_NETS(15)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef NETLIST_DEC_STATS_EN
        ,
        .stat_records(stat_records),
        .stat_shorted(stat_shorted)
`endif
    );

    typedef struct packed {
        logic [2:0]  typ;
        logic [3:0]  params;
        logic [3:0]  nets;
        logic        sh;
        logic        ovf;
        logic [15:0] hash;
    } rec_t;

    typedef struct {
        string line;
        bit    has_rec;
        rec_t  rec;
    } vec_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    rec_t exp_q[$];
    vec_t vecs[$];
    bit   drv_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [15:0] hash_str(input string s);
        logic [15:0] h;
        h = 16'd0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] != " " && s[i] != "\t") h = h * 16'd31 + {8'd0, s[i]};
        return h;
    endfunction

    function automatic rec_t mk(input int typ, input int params, input int nets,
                                input bit sh, input bit ovf, input string name);
        rec_t r;
        r.typ = 3'(typ); r.params = 4'(params); r.nets = 4'(nets);
        r.sh = sh; r.ovf = ovf; r.hash = hash_str(name);
        return r;
    endfunction

    function automatic rec_t dut_rec();
        return {bus.out_type, bus.out_params, bus.out_nets, bus.out_shorted,
                bus.out_ovf, bus.out_name_hash};
    endfunction

    task automatic add(input string line, input bit has_rec, input rec_t rec);
        vec_t v;
        v.line = line; v.has_rec = has_rec; v.rec = rec;
        vecs.push_back(v);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                n_chk++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic monitor();
        rec_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_record: got %0h expected none", dut_rec());
                end else begin
                    e = exp_q.pop_front();
                    check("record", dut_rec(), e);
                end
            end
        end
    endtask

    initial begin
        string s;
        rec_t  r1, r2;
        int    n;

        fork
            begin
                #300000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_fields", dut_rec(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        fork monitor(); join_none

        add("R #(.R(0 Ohm), .Temp(26.85)) R1(P1, P1);\n", 1, mk(1, 2, 2, 1, 0, "R1"));
        add("C #(.C(1 pF), .V(), .Symbol(neutral)) C1(gnd, P1);\n", 1, mk(2, 3, 2, 0, 0, "C1"));
        add("GND #() *(gnd);\n", 1, mk(3, 0, 1, 0, 0, "*"));
        add("painting incomplete\n", 0, '0);
        add("// .port_ x=30\n", 0, '0);
        add("module top(a, b);\n", 0, '0);
        add("R #(.R(1)) R2(a, b)\n", 0, '0);
        add("Rx #() Q(a, a);\n", 1, mk(0, 0, 2, 1, 0, "Q"));
        add("Foo #(.A(1), .B(2)) U7(n1, n2, n3);\n", 1, mk(0, 2, 3, 0, 0, "U7"));
        add("  \tC #() Cx (q, q);\n", 1, mk(2, 0, 2, 1, 0, "Cx"));
        add("Port #(.Num(1)) P1(a, b);\n", 1, mk(4, 1, 2, 0, 0, "P1"));
        s = "R #() X(";
        for (int i = 0; i < 17; i++) s = (i == 0) ? {s, "a"} : {s, ",a"};
        add({s, ");\n"}, 1, mk(1, 0, 15, 1, 1, "X"));
        s = "Z #(";
        for (int i = 0; i < 15; i++) s = (i == 0) ? {s, "p"} : {s, ",p"};
        add({s, ") U(n);\n"}, 1, mk(0, 15, 1, 0, 0, "U"));
        add({s, ",p) U(n);\n"}, 1, mk(0, 15, 1, 0, 1, "U"));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].has_rec) exp_q.push_back(vecs[i].rec);
            send_line(vecs[i].line);
        end
        wait_drain("table_drain");

        // Two back-to-back records with the consumer stalled for ten cycles.
        bus.out_ready = 1'b0;
        r1 = mk(1, 1, 2, 0, 0, "RA");
        r2 = mk(1, 1, 2, 1, 0, "RB");
        exp_q.push_back(r1);
        exp_q.push_back(r2);
        drv_done = 1'b0;
        fork
            begin
                send_line("R #(.R(1)) RA(a, b);\nR #(.R(2)) RB(c, c);\n");
                drv_done = 1'b1;
            end
        join_none
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", bus.out_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_hold", dut_rec(), r1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!drv_done && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("stall_driver_done", drv_done, 1);
        wait_drain("stall_drain");

        // Reset while a record is held: it must vanish at once.
        bus.out_ready = 1'b0;
        send_line("C #() C9(x, y);");
        check("emit_pending", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("emit_rst_out_valid", bus.out_valid, 0);
        check("emit_rst_fields", dut_rec(), 0);
        check("emit_rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a C line, then a complete Port line.
        s = "C #(.C(1 pF), .V(), .Symbol(neutral)) C1(gnd, P1);\n";
        send_line(s.substr(0, 19));
        #2 rst_n = 1'b0;
        #1;
        check("midline_rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4, 1, 2, 0, 0, "P2"));
        send_line("Port #(.Num(2)) P2(a, b);\n");
        wait_drain("midline_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
